// File: rtl/mem_loader_pkg.sv
// Shared types and helpers for the boot memory loader.
// Imported by the loader top and its interface.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    NEXT = 2'd2,
    DONE = 2'd3
  } ld_state_e;

  localparam int ADDR_LSB = 2;

  function automatic int unsigned sat_u(
    input int unsigned v,
    input int unsigned lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Stream-in / BRAM-write bundle of the boot loader.
// slave = loader side, master = source/memory side.
interface mem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int N_CH       = 2
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_dat;
  logic [N_CH-1:0]       w_enb;

  modport master (
    output s_valid, s_data,
    input  s_ready, w_addr, w_dat, w_enb
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, w_addr, w_dat, w_enb
  );
endinterface

// File: rtl/mem_loader.sv
// Boot loader: streams words into N_CH BRAMs in turn,
// holding the CPU stalled until every channel is filled.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int N_CH       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_CH*(ADDR_WIDTH-1)-1:0] word_cnt,
  mem_loader_if.slave                  bus,
  output logic                         busy,
  output logic                         done,
  output logic                         cpu_stall
);

  localparam int CW = ADDR_WIDTH - 1;
  localparam int IW = ADDR_WIDTH - ADDR_LSB;
  localparam int HW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned MAXW = 1 << IW;

  ld_state_e             state_q, state_d;
  logic [HW-1:0]         ch_q, ch_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q [N_CH];
  logic [CW-1:0]         cnt_d [N_CH];
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_dat_q, w_dat_d;
  logic [N_CH-1:0]       w_enb_q, w_enb_d;
  logic                  done_q, done_d;

  logic          hs;
  logic          last_ch;
  logic          last_idx;
  logic [CW-1:0] cur_cnt;

  assign cur_cnt  = cnt_q[ch_q];
  assign hs       = bus.s_valid && (state_q == LOAD);
  assign last_ch  = (ch_q == HW'(N_CH - 1));
  assign last_idx = ({1'b0, idx_q} == (cur_cnt - 1'b1));

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    w_addr_d = w_addr_q;
    w_dat_d  = w_dat_q;
    w_enb_d  = '0;
    done_d   = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Clamp so the byte address can never wrap.
          for (int k = 0; k < N_CH; k++) begin
            cnt_d[k] = CW'(sat_u(32'(word_cnt[k*CW +: CW]), MAXW));
          end
          ch_d    = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (cur_cnt != '0) begin
          state_d = LOAD;
        end else if (last_ch) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      LOAD: begin
        if (hs) begin
          w_enb_d[ch_q] = 1'b1;
          w_dat_d       = bus.s_data;
          w_addr_d      = {idx_q, 2'b00};
          if (last_idx) begin
            idx_d = '0;
            if (last_ch) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              ch_d    = ch_q + 1'b1;
              state_d = NEXT;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      idx_q    <= '0;
      w_addr_q <= '0;
      w_dat_q  <= '0;
      w_enb_q  <= '0;
      done_q   <= 1'b0;
      for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      idx_q    <= idx_d;
      w_addr_q <= w_addr_d;
      w_dat_q  <= w_dat_d;
      w_enb_q  <= w_enb_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.s_ready = (state_q == LOAD);
  assign bus.w_addr  = w_addr_q;
  assign bus.w_dat   = w_dat_q;
  assign bus.w_enb   = w_enb_q;
  assign busy        = (state_q == LOAD) || (state_q == NEXT);
  assign done        = done_q;
  assign cpu_stall   = !done_q;

endmodule
